// File: rtl/branch_predictor_pkg.sv
// Shared constants and types for the tournament (bimodal + gshare) branch predictor.
package branch_predictor_pkg;

    localparam logic [6:0] BR_OPCODE     = 7'b1100011;
    localparam int         CNT_W         = 2;
    localparam int         IDX_W_DEFAULT = 6;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_RESET = 2'b01;

endpackage

// File: rtl/branch_predictor_sat.sv
// 2-bit saturating up/down counter next-state logic, shared by all three predictor tables.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  cnt_t cnt,
    input  logic inc,
    input  logic dec,
    output cnt_t nxt
);

    // Simultaneous inc and dec cancel out, which gives the chooser its hold case.
    always_comb begin
        nxt = cnt;
        if (inc && !dec && cnt != '1)
            nxt = cnt + cnt_t'(1);
        else if (dec && !inc && cnt != '0)
            nxt = cnt - cnt_t'(1);
    end

endmodule

// File: rtl/branch_predictor.sv
// Tournament predictor: bimodal and gshare tables with a per-PC chooser, one-cycle lookup.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEFAULT,
    parameter int GHR_W = IDX_W
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      fetch_pc,
    input  logic [31:0]      fetch_inst,
    output logic             pred_valid,
    output logic             predict1,
    output logic             predict2,
    output logic             pprediction,
    output logic [IDX_W-1:0] pred_gidx,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic [IDX_W-1:0] res_gidx,
    input  logic             res_taken,
    input  logic             res_wrong1,
    input  logic             res_wrong2
);

    localparam int N = 1 << IDX_W;

    cnt_t bimodal [N];
    cnt_t gshare  [N];
    cnt_t chooser [N];
    logic [GHR_W-1:0] ghr;

    logic [IDX_W-1:0] fetch_bidx;
    logic [IDX_W-1:0] fetch_gidx;
    logic [IDX_W-1:0] res_bidx;
    logic             is_branch;
    logic             bim_taken;
    logic             gsh_taken;
    logic             use_gshare;
    cnt_t             bim_nxt;
    cnt_t             gsh_nxt;
    cnt_t             cho_nxt;
    logic             unused_bits;

    assign fetch_bidx = fetch_pc[IDX_W+1:2];
    assign fetch_gidx = fetch_bidx ^ ghr;
    assign res_bidx   = res_pc[IDX_W+1:2];
    assign is_branch  = (fetch_inst[6:0] == BR_OPCODE);

    assign bim_taken  = bimodal[fetch_bidx][CNT_W-1];
    assign gsh_taken  = gshare[fetch_gidx][CNT_W-1];
    assign use_gshare = chooser[fetch_bidx][CNT_W-1];

    assign unused_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0], fetch_inst[31:7],
                           res_pc[31:IDX_W+2], res_pc[1:0]};

    sat_counter2 u_bim_cnt (
        .cnt (bimodal[res_bidx]),
        .inc (res_taken),
        .dec (!res_taken),
        .nxt (bim_nxt)
    );

    sat_counter2 u_gsh_cnt (
        .cnt (gshare[res_gidx]),
        .inc (res_taken),
        .dec (!res_taken),
        .nxt (gsh_nxt)
    );

    // Chooser drifts toward whichever predictor was right when exactly one of them missed.
    sat_counter2 u_cho_cnt (
        .cnt (chooser[res_bidx]),
        .inc (res_wrong1 && !res_wrong2),
        .dec (res_wrong2 && !res_wrong1),
        .nxt (cho_nxt)
    );

    // Tables are read combinationally before this edge's update lands: read-before-write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_valid  <= 1'b0;
            predict1    <= 1'b0;
            predict2    <= 1'b0;
            pprediction <= 1'b0;
            pred_gidx   <= '0;
        end else begin
            pred_valid  <= is_branch;
            predict1    <= is_branch && bim_taken;
            predict2    <= is_branch && gsh_taken;
            pprediction <= is_branch && (use_gshare ? gsh_taken : bim_taken);
            pred_gidx   <= fetch_gidx;
        end
    end

    // History only advances on resolution, never speculatively at fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                bimodal[i] <= CNT_RESET;
                gshare[i]  <= CNT_RESET;
                chooser[i] <= CNT_RESET;
            end
            ghr <= '0;
        end else if (res_valid) begin
            bimodal[res_bidx] <= bim_nxt;
            gshare[res_gidx]  <= gsh_nxt;
            chooser[res_bidx] <= cho_nxt;
            ghr               <= {ghr[GHR_W-2:0], res_taken};
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven checks of the tournament branch predictor with hand-computed expectations.
module tb_branch_predictor;

    localparam logic [31:0] BR  = 32'h0000_0063;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        pred_valid;
    logic        predict1;
    logic        predict2;
    logic        pprediction;
    logic [5:0]  pred_gidx;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [5:0]  res_gidx;
    logic        res_taken;
    logic        res_wrong1;
    logic        res_wrong2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rv;
        logic [31:0] rpc;
        logic [5:0]  rg;
        logic        rt;
        logic        w1;
        logic        w2;
        logic        ev;
        logic        e1;
        logic        e2;
        logic        ep;
        logic [5:0]  eg;
    } vec_t;

    vec_t vecs [15];

    branch_predictor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_pc    (fetch_pc),
        .fetch_inst  (fetch_inst),
        .pred_valid  (pred_valid),
        .predict1    (predict1),
        .predict2    (predict2),
        .pprediction (pprediction),
        .pred_gidx   (pred_gidx),
        .res_valid   (res_valid),
        .res_pc      (res_pc),
        .res_gidx    (res_gidx),
        .res_taken   (res_taken),
        .res_wrong1  (res_wrong1),
        .res_wrong2  (res_wrong2)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] inst, input logic rv,
                                 input logic [31:0] rpc, input logic [5:0] rg, input logic rt,
                                 input logic w1, input logic w2);
        fetch_pc   = pc;
        fetch_inst = inst;
        res_valid  = rv;
        res_pc     = rpc;
        res_gidx   = rg;
        res_taken  = rt;
        res_wrong1 = w1;
        res_wrong2 = w2;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic ev, input logic e1, input logic e2,
                            input logic ep, input logic [5:0] eg);
        checkOutput({tag, " pred_valid"},  32'(pred_valid),  32'(ev));
        checkOutput({tag, " predict1"},    32'(predict1),    32'(e1));
        checkOutput({tag, " predict2"},    32'(predict2),    32'(e2));
        checkOutput({tag, " pprediction"}, 32'(pprediction), 32'(ep));
        checkOutput({tag, " pred_gidx"},   32'(pred_gidx),   32'(eg));
    endtask

    initial begin
        // pc, inst, rv, rpc, rg, rt, w1, w2 | valid, p1, p2, pp, gidx
        vecs[0]  = '{32'h100, BR,  1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00};
        vecs[1]  = '{32'h100, BR,  1'b1, 32'h100, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00};
        vecs[2]  = '{32'h100, BR,  1'b1, 32'h100, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h01};
        vecs[3]  = '{32'h100, BR,  1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h03};
        vecs[4]  = '{32'h100, NOP, 1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h03};
        vecs[5]  = '{32'h000, NOP, 1'b1, 32'h040, 6'h05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h03};
        vecs[6]  = '{32'h000, NOP, 1'b1, 32'h040, 6'h05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h07};
        vecs[7]  = '{32'h000, NOP, 1'b1, 32'h040, 6'h05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0F};
        vecs[8]  = '{32'h040, BR,  1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h0F};
        vecs[9]  = '{32'h040, BR,  1'b1, 32'h040, 6'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'h0F};
        vecs[10] = '{32'h040, BR,  1'b1, 32'h040, 6'h2F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'h2F};
        vecs[11] = '{32'h040, BR,  1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h2E};
        vecs[12] = '{32'h040, BR,  1'b1, 32'h040, 6'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h2E};
        vecs[13] = '{32'h040, BR,  1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h2D};
        vecs[14] = '{32'h0F4, BR,  1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h00};

        // Reset with a branch on the fetch port: outputs must still clear.
        rst_n = 1'b0;
        applyStimulus(32'h100, BR, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h100, BR, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b0);
        checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].pc, vecs[i].inst, vecs[i].rv, vecs[i].rpc, vecs[i].rg,
                          vecs[i].rt, vecs[i].w1, vecs[i].w2);
            checkAll($sformatf("vec%0d", i), vecs[i].ev, vecs[i].e1, vecs[i].e2,
                     vecs[i].ep, vecs[i].eg);
        end

        // Reset coinciding with a resolution: the resolution is discarded.
        rst_n = 1'b0;
        applyStimulus(32'h100, BR, 1'b1, 32'h100, 6'h00, 1'b1, 1'b1, 1'b0);
        checkAll("rst_res", 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        rst_n = 1'b1;
        applyStimulus(32'h100, BR, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b0);
        checkAll("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 6'h00);
        applyStimulus(32'h100, BR, 1'b1, 32'h100, 6'h00, 1'b1, 1'b1, 1'b0);
        checkAll("post_rst_res", 1'b1, 1'b0, 1'b0, 1'b0, 6'h00);
        applyStimulus(32'h100, BR, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b0);
        checkAll("post_rst_upd", 1'b1, 1'b1, 1'b0, 1'b0, 6'h01);

        // Bimodal counter must stick at 00 rather than wrap when driven down repeatedly.
        for (int k = 0; k < 3; k++)
            applyStimulus(32'h0, NOP, 1'b1, 32'h008, 6'h3F, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h0, NOP, 1'b1, 32'h008, 6'h3F, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h008, BR, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_low predict1", 32'(predict1), 32'd0);
        checkOutput("sat_low pred_valid", 32'(pred_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
